// File: rtl/tile_pkg.sv
// Shared widths, request payload and FSM encoding for the tile RAM writer.
package tile_pkg;

    localparam int unsigned TILE_ADDR_W = 10;
    localparam int unsigned TILE_DATA_W = 8;
    localparam int unsigned TILE_CELLS  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } tile_state_e;

    typedef struct packed {
        logic [TILE_ADDR_W-1:0] addr;
        logic [TILE_DATA_W-1:0] data;
    } tile_req_t;

endpackage

// File: rtl/tile_req_fifo.sv
// Write-request queue of {addr,data} entries; head is visible combinationally.
module tile_req_fifo
    import tile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  tile_req_t             push_data,
    input  logic                  pop,
    output tile_req_t             head,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    tile_req_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rptr];

    // A full queue refuses a push even if a pop frees a slot this cycle.
    assign w_wr = push && !full;
    assign w_rd = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
            if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= push_data;
    end

endmodule

// File: rtl/tile_ram_writer.sv
// Arbitrates tile RAM writes (queued requests and full clears) into display blanking.
// Optional TILE_WRITER_STATS_EN adds a 16-bit write_count output.
module tile_ram_writer
    import tile_pkg::*;
#(
    parameter int unsigned            FIFO_DEPTH  = 4,
    parameter logic [TILE_DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   display_on,
    input  logic [TILE_ADDR_W-1:0] disp_addr,
    input  logic                   req_valid,
    input  logic [TILE_ADDR_W-1:0] req_addr,
    input  logic [TILE_DATA_W-1:0] req_data,
    output logic                   req_ready,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic [TILE_ADDR_W-1:0] ram_addr,
    output logic [TILE_DATA_W-1:0] ram_wdata,
    output logic                   ram_we
`ifdef TILE_WRITER_STATS_EN
    ,
    output logic [15:0]            write_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    tile_state_e            r_state;
    logic [TILE_ADDR_W-1:0] r_clr_cnt;
    tile_req_t              w_head;
    tile_req_t              w_push_data;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;
    logic                   w_push;
    logic                   w_blank;
    logic                   w_pop;
    logic                   w_clr_wr;
    logic                   w_clr_last;

    assign req_ready   = (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push      = req_valid && !w_full;
    assign w_push_data = '{addr: req_addr, data: req_data};

    // Writes only in blanking; a cycle with reset low never writes.
    assign w_blank    = reset && !display_on;
    assign w_clr_wr   = w_blank && (r_state == ST_CLEAR);
    assign w_pop      = w_blank && (r_state != ST_CLEAR) && !w_empty;
    assign w_clr_last = (r_clr_cnt == TILE_ADDR_W'(TILE_CELLS - 1));
    assign clear_busy = (r_state == ST_CLEAR);

    tile_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // RAM port mux: clear data, queue head, or display scan address.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = w_head.data;
        if (w_clr_wr) begin
            ram_we    = 1'b1;
            ram_addr  = r_clr_cnt;
            ram_wdata = CLEAR_VALUE;
        end else if (w_pop) begin
            ram_we    = 1'b1;
            ram_addr  = w_head.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end else if (!w_empty) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (clear_start) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end else if (w_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_wr) begin
                        if (w_clr_last) begin
                            r_state   <= w_empty ? ST_IDLE : ST_DRAIN;
                            r_clr_cnt <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + TILE_ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef TILE_WRITER_STATS_EN
    logic [15:0] r_write_count;

    assign write_count = r_write_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_write_count <= '0;
        end else if (ram_we) begin
            r_write_count <= r_write_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_ram_writer.sv
// Bench for tile_ram_writer: queue-level reference model, directed scenarios and random traffic.
module tb_tile_ram_writer;
    import tile_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  CLR   = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       display_on;
    logic [9:0] disp_addr;
    logic       req_valid;
    logic [9:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready;
    logic       clear_start;
    logic       clear_busy;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
`ifdef TILE_WRITER_STATS_EN
    logic [15:0] write_count;
`endif

    always #5 clk = ~clk;

    tile_ram_writer #(
        .FIFO_DEPTH  (DEPTH),
        .CLEAR_VALUE (CLR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .display_on  (display_on),
        .disp_addr   (disp_addr),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we)
`ifdef TILE_WRITER_STATS_EN
        ,
        .write_count (write_count)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: pending requests, clear in progress, next clear address.
    logic [17:0] mq[$];
    logic [17:0] trace[$];
    bit          m_clear = 1'b0;
    int          m_cnt   = 0;
    int          m_wc    = 0;
    bit          m_busy;
    bit          m_full;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [7:0]  e_data;

    int base, n, bad, idx1023, last7;
    logic [7:0] data7;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_we   = reset && !display_on && (m_clear || mq.size() > 0);
            e_addr = disp_addr;
            e_data = 8'h00;
            if (e_we && m_clear) begin
                e_addr = 10'(m_cnt);
                e_data = CLR;
            end else if (e_we) begin
                e_addr = mq[0][17:8];
                e_data = mq[0][7:0];
            end
            check("ram_we", 32'(ram_we), 32'(e_we));
            check("ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(e_data));
            check("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            check("clear_busy", 32'(clear_busy), 32'(m_clear));
`ifdef TILE_WRITER_STATS_EN
            check("write_count", 32'(write_count), 32'(m_wc));
`endif
            if (ram_we === 1'b1) trace.push_back({ram_addr, ram_wdata});
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            if (!reset) begin
                mq.delete();
                m_clear = 1'b0;
                m_cnt   = 0;
                m_wc    = 0;
            end else begin
                m_busy = m_clear;
                m_full = (mq.size() >= DEPTH);
                if (!display_on) begin
                    if (m_clear) begin
                        m_wc  = (m_wc + 1) % 65536;
                        m_cnt = m_cnt + 1;
                        if (m_cnt == TILE_CELLS) begin
                            m_clear = 1'b0;
                            m_cnt   = 0;
                        end
                    end else if (mq.size() > 0) begin
                        m_wc = (m_wc + 1) % 65536;
                        void'(mq.pop_front());
                    end
                end
                if (!m_busy && clear_start) begin
                    m_clear = 1'b1;
                    m_cnt   = 0;
                end
                if (req_valid && !m_full) mq.push_back({req_addr, req_data});
            end
        end
    end

    task automatic wait_clear_end(input string name);
        n = 0;
        smp();
        while (clear_busy === 1'b1 && n < 1100) begin
            tick();
            smp();
            n++;
        end
        check(name, 32'(clear_busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; display_on = 1'b1; disp_addr = 10'h2A5;
        req_valid = 1'b0; req_addr = '0; req_data = '0; clear_start = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        reset  = 1'b1;
        smp();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr_follow", 32'(ram_addr), 32'h2A5);

        // Single request during blanking lands exactly one cycle later.
        tick();
        display_on = 1'b0; req_valid = 1'b1; req_addr = 10'h005; req_data = 8'h3C;
        smp();
        check("t1_not_same_cycle", 32'(ram_we), 32'd0);
        tick();
        req_valid = 1'b0;
        smp();
        check("t1_we", 32'(ram_we), 32'd1);
        check("t1_addr", 32'(ram_addr), 32'h005);
        check("t1_data", 32'(ram_wdata), 32'h3C);
        tick(); smp();
        check("t1_single", 32'(ram_we), 32'd0);

        // Fill during display, then drain in order once blanking starts.
        tick();
        display_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 10'(32'h040 + i); req_data = 8'(32'hA0 + i);
            smp();
            check("t2_hold_we", 32'(ram_we), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        smp();
        check("t2_full_ready", 32'(req_ready), 32'd0);
        tick();
        display_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("t2_we", 32'(ram_we), 32'd1);
            check("t2_addr", 32'(ram_addr), 32'h040 + 32'(i));
            check("t2_data", 32'(ram_wdata), 32'hA0 + 32'(i));
            tick();
        end
        smp();
        check("t2_done", 32'(ram_we), 32'd0);

        // Full clear with permanent blanking.
        tick();
        base = trace.size();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        smp();
        check("t3_busy", 32'(clear_busy), 32'd1);
        tick();
        wait_clear_end("t3_busy_end");
        repeat (5) tick();
        smp();
        check("t3_write_total", 32'(trace.size() - base), 32'd1024);
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (base + i >= trace.size() || trace[base + i] !== {10'(i), 8'h00}) bad++;
        check("t3_clear_sequence", 32'(bad), 32'd0);

        // Request queued during a clear lands after address 1023.
        tick();
        base = trace.size();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (10) tick();
        req_valid = 1'b1; req_addr = 10'd7; req_data = 8'h55;
        tick();
        req_valid = 1'b0;
        wait_clear_end("t4_busy_end");
        repeat (4) tick();
        smp();
        idx1023 = -1; last7 = -1; data7 = 8'hXX;
        for (int i = base; i < trace.size(); i++) begin
            if (trace[i][17:8] == 10'd1023) idx1023 = i;
            if (trace[i][17:8] == 10'd7) begin last7 = i; data7 = trace[i][7:0]; end
        end
        check("t4_final_data7", 32'(data7), 32'h55);
        check("t4_after_1023", 32'(last7 > idx1023 && idx1023 >= 0), 32'd1);

        // Reset in the middle of a clear stops it cold.
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        n = 0;
        smp();
        while (!(ram_we === 1'b1 && ram_addr === 10'd299) && n < 1100) begin
            tick();
            smp();
            n++;
        end
        check("t5_reach_299", 32'(n < 1100), 32'd1);
        tick();
        reset = 1'b0;
        smp();
        check("t5_gate_we", 32'(ram_we), 32'd0);
        tick();
        reset = 1'b1;
        smp();
        check("t5_busy", 32'(clear_busy), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_we", 32'(ram_we), 32'd0);
        base = trace.size();
        repeat (30) tick();
        smp();
        check("t5_no_more_writes", 32'(trace.size() - base), 32'd0);

        // Full queue: simultaneous pop and request, request refused.
        tick();
        display_on = 1'b1;
        base = trace.size();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 10'(32'h100 + i); req_data = 8'(32'h10 + i);
            tick();
        end
        display_on = 1'b0; req_valid = 1'b1; req_addr = 10'h3FF; req_data = 8'hEE;
        smp();
        check("t6_full_ready", 32'(req_ready), 32'd0);
        check("t6_pop_we", 32'(ram_we), 32'd1);
        tick();
        req_valid = 1'b0;
        smp();
        check("t6_count_dropped", 32'(req_ready), 32'd1);
        repeat (6) tick();
        smp();
        check("t6_write_total", 32'(trace.size() - base), 32'd4);
        bad = 0;
        for (int i = base; i < trace.size(); i++)
            if (trace[i][17:8] == 10'h3FF) bad++;
        check("t6_rejected_absent", 32'(bad), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            display_on  = ($urandom_range(0, 2) == 0);
            disp_addr   = 10'($urandom);
            req_valid   = 1'($urandom_range(0, 1));
            req_addr    = 10'($urandom);
            req_data    = 8'($urandom);
            clear_start = ($urandom_range(0, 799) == 0);
            reset       = ($urandom_range(0, 1499) != 0);
            tick();
        end
        reset = 1'b1; display_on = 1'b0; req_valid = 1'b0; clear_start = 1'b0;
        tick();
        wait_clear_end("rnd_busy_end");
        repeat (8) tick();
        smp();
        check("rnd_idle_ready", 32'(req_ready), 32'd1);
        check("rnd_idle_we", 32'(ram_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
